// File: rtl/servo_bank_if.sv
// Register bus between a host and servo_bank: byte-wide address/data with
// separate write and read strobes and registered read data.
interface servo_bank_if;
   logic [7:0] din;
   logic [7:0] address;
   logic       w_en;
   logic       r_en;
   logic [7:0] dout;

   modport master (output din, address, w_en, r_en, input dout);
   modport slave  (input din, address, w_en, r_en, output dout);
endinterface

// File: rtl/servo_bank.sv
// servo_bank: register-mapped bank of servo PWM channels sharing one prescaler and frame counter.
// Optional feature macro SERVO_SLEW_EN: rate-limit CUR toward TARGET by STEP on every frame start.
module servo_bank #(
   parameter int         NUM_CHANNELS = 4,
   parameter logic [7:0] BASE_ADDRESS = 8'h00,
   parameter int         PRESCALE     = 102,
   parameter int         PERIOD_TICKS = 3150,
   parameter int         MIN_TICKS    = 91
) (
   input  logic                    clk,
   input  logic                    rst_n,
   servo_bank_if.slave             bus,
   output logic [NUM_CHANNELS-1:0] servo_pins
);
   localparam int          NREG       = NUM_CHANNELS + 3;
   localparam logic [7:0]  OFF_ENABLE = 8'(NUM_CHANNELS);
   localparam logic [7:0]  OFF_STEP   = 8'(NUM_CHANNELS + 1);
   localparam logic [7:0]  OFF_BUSY   = 8'(NUM_CHANNELS + 2);
   localparam logic [15:0] PRESCALE_W = 16'(PRESCALE);
   localparam logic [11:0] PERIOD_W   = 12'(PERIOD_TICKS);
   localparam logic [11:0] MIN_W      = 12'(MIN_TICKS);

   logic [15:0]             r_presc;
   logic                    r_tick;
   logic [11:0]             r_cnt;
   logic [7:0]              r_target [NUM_CHANNELS];
   logic [7:0]              r_cur    [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] r_enable;
   logic [7:0]              r_dout;
   logic [NUM_CHANNELS-1:0] r_pins;
`ifdef SERVO_SLEW_EN
   logic [7:0]              r_step;
`endif

   logic [8:0]              w_diff9;
   logic [7:0]              w_off;
   logic                    w_hit;
   logic                    w_wr_hit;
   logic                    w_mapped;
   logic                    w_frame_start;
   logic [7:0]              w_rdata;
   logic [7:0]              w_enable8;
   logic [7:0]              w_busy8;
   logic [7:0]              w_cur_next [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] w_pin_next;
   logic [NUM_CHANNELS-1:0] w_busy;

   // 9-bit subtraction so addresses below the base never alias into the map
   assign w_diff9  = {1'b0, bus.address} - {1'b0, BASE_ADDRESS};
   assign w_off    = w_diff9[7:0];
   assign w_hit    = !w_diff9[8] && (w_off < 8'(NREG));
   assign w_wr_hit = bus.w_en && w_hit;
`ifdef SERVO_SLEW_EN
   assign w_mapped = w_hit;
`else
   assign w_mapped = w_hit && (w_off != OFF_STEP);
`endif

   assign w_frame_start = r_tick && (r_cnt == PERIOD_W);
   assign w_enable8     = 8'(r_enable);
   assign w_busy8       = 8'(w_busy);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
`ifdef SERVO_SLEW_EN
         logic [7:0] w_up;
         logic [7:0] w_dn;
         assign w_up = r_target[gi] - r_cur[gi];
         assign w_dn = r_cur[gi] - r_target[gi];
         // A step never passes the target, so the sums below cannot wrap
         assign w_cur_next[gi] = (r_step == 8'd0)           ? r_target[gi] :
                                 (r_target[gi] > r_cur[gi]) ? ((w_up > r_step) ? r_cur[gi] + r_step : r_target[gi]) :
                                                              ((w_dn > r_step) ? r_cur[gi] - r_step : r_target[gi]);
`else
         assign w_cur_next[gi] = r_target[gi];
`endif
         assign w_pin_next[gi] = r_enable[gi] && (({4'h0, r_cur[gi]} + MIN_W) > r_cnt);
         assign w_busy[gi]     = (r_cur[gi] != r_target[gi]);
      end
   endgenerate

   always_comb begin
      w_rdata = 8'h00;
      if (w_mapped) begin
         if (w_off == OFF_ENABLE)
            w_rdata = w_enable8;
         else if (w_off == OFF_BUSY)
            w_rdata = w_busy8;
`ifdef SERVO_SLEW_EN
         else if (w_off == OFF_STEP)
            w_rdata = r_step;
`endif
         else begin
            for (int i = 0; i < NUM_CHANNELS; i++)
               if (w_off == 8'(i))
                  w_rdata = r_target[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc  <= '0;
         r_tick   <= 1'b0;
         r_cnt    <= '0;
         r_enable <= '0;
         r_dout   <= '0;
         r_pins   <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_target[i] <= '0;
            r_cur[i]    <= '0;
         end
`ifdef SERVO_SLEW_EN
         r_step   <= '0;
`endif
      end else begin
         if (r_presc == PRESCALE_W) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
         end else begin
            r_presc <= r_presc + 16'd1;
            r_tick  <= 1'b0;
         end
         if (r_tick)
            r_cnt <= (r_cnt == PERIOD_W) ? 12'd0 : r_cnt + 12'd1;

         // CUR samples TARGET before any same-edge write lands
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_frame_start)
               r_cur[i] <= w_cur_next[i];
            if (w_wr_hit && (w_off == 8'(i)))
               r_target[i] <= bus.din;
         end
         if (w_wr_hit && (w_off == OFF_ENABLE))
            r_enable <= bus.din[NUM_CHANNELS-1:0];
`ifdef SERVO_SLEW_EN
         if (w_wr_hit && (w_off == OFF_STEP))
            r_step <= bus.din;
`endif

         r_pins <= w_pin_next;

         if (bus.r_en)
            r_dout <= w_rdata;
         else if (!w_mapped)
            r_dout <= 8'h00;
      end
   end

   assign bus.dout   = r_dout;
   assign servo_pins = r_pins;
endmodule

// File: doc/servo_bank.md
SERVO_BANK -- requirements
Module: servo_bank

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4: servo channel count, legal range 1..8.
REQ-002 SHALL have parameter BASE_ADDRESS, default 8'h00: first register address of the block.
REQ-003 SHALL have parameter PRESCALE, default 102: a tick occurs every PRESCALE+1 clocks.
REQ-004 SHALL have parameter PERIOD_TICKS, default 3150: frame counter terminal value, 12-bit.
REQ-005 SHALL have parameter MIN_TICKS, default 91: pulse width in ticks at position 0.
REQ-006 SHALL have port clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port din, input, 8 bits: write data.
REQ-009 SHALL have port address, input, 8 bits: register address.
REQ-010 SHALL have port w_en, input, 1 bit: write strobe.
REQ-011 SHALL have port r_en, input, 1 bit: read strobe.
REQ-012 SHALL have port dout, output reg, 8 bits: registered read data.
REQ-013 SHALL have port servo_pins, output reg, NUM_CHANNELS bits: one PWM output per channel.

Function
REQ-014 SHALL map registers as follows: TARGET[i] at BASE_ADDRESS+i (RW); ENABLE mask at BASE_ADDRESS+NUM_CHANNELS (RW, bits above NUM_CHANNELS-1 read 0); STEP at +NUM_CHANNELS+1 (RW); BUSY mask at +NUM_CHANNELS+2 (RO, writes ignored).
REQ-015 SHALL apply a write on the clock edge where w_en=1 and address matches.
REQ-016 SHALL present read data on dout one clock after r_en=1.
REQ-017 SHALL hold dout when r_en=0 and the address is mapped, and SHALL load dout with 0 when the address is unmapped.
REQ-018 SHALL, on simultaneous w_en and r_en to the same register, return the pre-write value.
REQ-019 SHALL count the prescaler 0..PRESCALE, wrap to 0, and pulse tick high for exactly one clock on each wrap.
REQ-020 SHALL advance the 12-bit frame counter only on tick, counting 0..PERIOD_TICKS and wrapping to 0. The tick on which it wraps is frame_start.
REQ-021 SHALL keep an internal 8-bit CUR[i] per channel and update it only on frame_start, so pulses never change mid-frame.
REQ-022 SHALL drive servo_pins[i] registered, high iff ENABLE[i]=1 and counter < MIN_TICKS+CUR[i], computed at 12-bit width without overflow. Pulse width is MIN_TICKS+CUR[i] ticks.
REQ-023 SHALL, when ENABLE[i] is cleared, force servo_pins[i] low on the next clock; re-enabling mid-frame resumes comparison on the next clock.
REQ-024 SHALL use the TARGET value registered before a write coinciding with frame_start; the new value applies at the next frame_start.
REQ-025 SHALL set BUSY[i]=1 whenever CUR[i]!=TARGET[i].

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk: clear prescaler, tick, counter, all CUR, TARGET, ENABLE, STEP, and dout to 0, and drive servo_pins to 0.
REQ-027 SHALL resume counting from 0 on the first clock edge after rst_n rises. Reset mid-pulse drops the pin immediately.

Configuration
REQ-028 SHALL, with SERVO_SLEW_EN defined, move CUR[i] toward TARGET[i] on each frame_start by min(STEP, |TARGET[i]-CUR[i]|); STEP=0 SHALL load TARGET directly; no overshoot or 8-bit wrap SHALL occur.
REQ-029 SHALL, without SERVO_SLEW_EN, load CUR[i]<=TARGET[i] on every frame_start; the STEP address is unmapped (reads 0, writes ignored).

Verification
REQ-030 SHALL cover: defaults, ENABLE=0x01, TARGET[0]=0 -> pin0 high 91 ticks (9373 clocks) per 324553-clock frame; pins 1-3 stay low.
REQ-031 SHALL cover: TARGET[0]=255 written mid-frame -> current frame unchanged; next frame high 346 ticks (35638 clocks).
REQ-032 SHALL cover: with SERVO_SLEW_EN, STEP=10, CUR=0, TARGET=255 -> width grows by 10 ticks per frame; reaches 255 on the 26th frame_start; BUSY bit0 clears then.
REQ-033 SHALL cover: read TARGET[2] after writing 0x5A -> dout=0x5A one clock after r_en; read of address BASE+0x20 -> dout=0.
REQ-034 SHALL cover: rst_n driven low mid-pulse -> all pins and dout 0 before the next clk edge; after release the first pulse starts at frame counter 0.
REQ-035 SHALL cover: ENABLE cleared during a pulse -> pin low next clock; write at frame_start of TARGET -> old value used for that frame.
